// File: rtl/frame_loader.sv
// frame_loader: assembles IN_W-bit symbol beats into FRAME_W-bit frames.
// Two ping-pong banks buffer up to two complete frames. The oldest frame is
// presented to the decoder until the decoder acknowledges it.
module frame_loader #(
  parameter int FRAME_W = 276,
  parameter int IN_W    = 4
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic [IN_W-1:0]    i_data,
  input  logic               i_valid,
  input  logic               i_sof,
  input  logic               i_flush,
  input  logic               i_frame_ack,
  output logic               o_ready,
  output logic [FRAME_W-1:0] o_frame,
  output logic               o_frame_valid,
  output logic [1:0]         o_held,
  output logic               o_err
);

  localparam int unsigned BEATS = FRAME_W / IN_W;
  localparam int          CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_beat, w_beat_nx, w_widx;
  logic            r_wptr, w_wptr_nx;
  logic            r_rptr, w_rptr_nx;
  logic [1:0]      r_count, w_count_nx;
  logic            r_ready, w_ready_nx;
  logic            r_err, w_err_nx;
  logic            w_we, w_done;
  logic            w_xfer, w_ack;
  logic [FRAME_W-1:0] r_bank [2];

  assign w_xfer = i_valid && r_ready;
  // An ack is only meaningful while a frame is being presented.
  assign w_ack  = i_frame_ack && (r_count != 2'd0);

  // Next-state, bank write control and buffer bookkeeping.
  always_comb begin
    w_state_nx = r_state;
    w_beat_nx  = r_beat;
    w_wptr_nx  = r_wptr;
    w_rptr_nx  = r_rptr;
    w_count_nx = r_count;
    w_ready_nx = r_ready;
    w_err_nx   = 1'b0;
    w_we       = 1'b0;
    w_widx     = '0;
    w_done     = 1'b0;
    if (i_flush) begin
      w_state_nx = IDLE;
      w_beat_nx  = '0;
      w_wptr_nx  = 1'b0;
      w_rptr_nx  = 1'b0;
      w_count_nx = 2'd0;
      w_ready_nx = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer && i_sof) begin
            w_we       = 1'b1;
            w_widx     = '0;
            w_beat_nx  = CW'(1);
            w_state_nx = FILL;
          end
        end
        FILL: begin
          if (w_xfer) begin
            w_we = 1'b1;
            if (i_sof) begin
              w_widx    = '0;
              w_beat_nx = CW'(1);
              w_err_nx  = 1'b1;
            end else begin
              w_widx = r_beat;
              if (r_beat == CW'(BEATS - 1)) begin
                w_done     = 1'b1;
                w_beat_nx  = '0;
                w_state_nx = IDLE;
                w_wptr_nx  = ~r_wptr;
              end else begin
                w_beat_nx = r_beat + CW'(1);
              end
            end
          end
        end
        default: w_state_nx = IDLE;
      endcase
      if (w_ack) w_rptr_nx = ~r_rptr;
      case ({w_done, w_ack})
        2'b10:   w_count_nx = r_count + 2'd1;
        2'b01:   w_count_nx = r_count - 2'd1;
        default: w_count_nx = r_count;
      endcase
      w_ready_nx = (w_count_nx < 2'd2);
    end
  end

  // Control state register; reset clears validity only, never bank data.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_beat  <= w_beat_nx;
      r_wptr  <= w_wptr_nx;
      r_rptr  <= w_rptr_nx;
      r_count <= w_count_nx;
      r_ready <= w_ready_nx;
      r_err   <= w_err_nx;
    end
  end

  // Bank storage: beat k lands in the k-th IN_W slice from the MSB end.
  always_ff @(posedge sys_clk) begin
    if (w_we) begin
      for (int unsigned b = 0; b < BEATS; b++) begin
        if (w_widx == CW'(b)) r_bank[r_wptr][FRAME_W-1-b*IN_W -: IN_W] <= i_data;
      end
    end
  end

  assign o_frame       = r_bank[r_rptr];
  assign o_frame_valid = (r_count != 2'd0);
  assign o_held        = r_count;
  assign o_ready       = r_ready;
  assign o_err         = r_err;

endmodule

// File: tb/tb_frame_loader.sv
// Self-checking bench for frame_loader: directed scenarios plus random
// traffic, checked against a queue-based frame model.
module tb_frame_loader;

  localparam int FRAME_W = 276;
  localparam int IN_W    = 4;
  localparam int BEATS   = FRAME_W / IN_W;

  typedef logic [FRAME_W-1:0] frame_t;

  logic               sys_clk = 1'b0;
  logic               rst     = 1'b0;
  logic [IN_W-1:0]    i_data  = '0;
  logic               i_valid = 1'b0;
  logic               i_sof   = 1'b0;
  logic               i_flush = 1'b0;
  logic               i_frame_ack = 1'b0;
  logic               o_ready;
  logic [FRAME_W-1:0] o_frame;
  logic               o_frame_valid;
  logic [1:0]         o_held;
  logic               o_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of complete frames plus the frame being assembled.
  frame_t m_q[$];
  frame_t m_buf;
  bit     m_ready = 1'b0;
  bit     m_in    = 1'b0;
  bit     m_err   = 1'b0;
  int     m_k     = 0;

  frame_loader #(.FRAME_W(FRAME_W), .IN_W(IN_W)) dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .i_data        (i_data),
    .i_valid       (i_valid),
    .i_sof         (i_sof),
    .i_flush       (i_flush),
    .i_frame_ack   (i_frame_ack),
    .o_ready       (o_ready),
    .o_frame       (o_frame),
    .o_frame_valid (o_frame_valid),
    .o_held        (o_held),
    .o_err         (o_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input frame_t got, input frame_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_in    = 1'b0;
    m_k     = 0;
    m_err   = 1'b0;
    m_ready = 1'b0;
  endfunction

  function automatic void model_clk(bit v, logic [IN_W-1:0] d, bit s, bit f, bit a);
    bit ack_eff;
    m_err = 1'b0;
    if (f) begin
      m_q.delete();
      m_in    = 1'b0;
      m_k     = 0;
      m_ready = 1'b1;
      return;
    end
    ack_eff = a && (m_q.size() > 0);
    if (v && m_ready) begin
      if (s) begin
        if (m_in) m_err = 1'b1;
        m_in = 1'b1;
        m_k  = 0;
      end
      if (m_in) begin
        m_buf[FRAME_W-1-m_k*IN_W -: IN_W] = d;
        m_k++;
        if (m_k == BEATS) begin
          m_q.push_back(m_buf);
          m_in = 1'b0;
          m_k  = 0;
        end
      end
    end
    if (ack_eff) void'(m_q.pop_front());
    m_ready = (m_q.size() < 2);
  endfunction

  // One clock: drive, let the edge happen, update model, check outputs.
  task automatic step(input bit v, input logic [IN_W-1:0] d, input bit s,
                      input bit f, input bit a);
    i_valid = v; i_data = d; i_sof = s; i_flush = f; i_frame_ack = a;
    @(posedge sys_clk);
    model_clk(v, d, s, f, a);
    #1;
    chk("ready",  frame_t'(o_ready),       frame_t'(m_ready));
    chk("held",   frame_t'(o_held),        frame_t'(m_q.size()));
    chk("fvalid", frame_t'(o_frame_valid), frame_t'(m_q.size() != 0));
    chk("err",    frame_t'(o_err),         frame_t'(m_err));
    if (m_q.size() > 0) chk("frame", o_frame, m_q[0]);
    i_valid = 1'b0; i_sof = 1'b0; i_flush = 1'b0; i_frame_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < BEATS; i++) f[FRAME_W-1-i*IN_W -: IN_W] = IN_W'($urandom);
    return f;
  endfunction

  // Send beats first_k..BEATS-1 of fr, holding each until the model accepts it.
  task automatic send_frame(input frame_t fr, input int first_k,
                            input bit ack_last, input bit stall_ack);
    int k = first_k;
    int guard = 0;
    int stall = 0;
    bit acc, a;
    while (k < BEATS && guard < 1000) begin
      a = 1'b0;
      if (stall_ack && !m_ready && stall >= 4) begin
        a = 1'b1;
        stall = 0;
      end
      if (ack_last && k == BEATS - 1 && m_ready) a = 1'b1;
      acc = m_ready;
      if (!m_ready) stall++;
      step(1'b1, fr[FRAME_W-1-k*IN_W -: IN_W], (k == 0), 1'b0, a);
      if (acc) k++;
      guard++;
    end
    chk("send_in_budget", frame_t'(guard < 1000), frame_t'(1));
  endtask

  task automatic partial(input int n);
    for (int k = 0; k < n; k++) step(1'b1, IN_W'($urandom), (k == 0), 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("rst_ready",  frame_t'(o_ready),       frame_t'(0));
    chk("rst_fvalid", frame_t'(o_frame_valid), frame_t'(0));
    chk("rst_held",   frame_t'(o_held),        frame_t'(0));
    chk("rst_err",    frame_t'(o_err),         frame_t'(0));
    @(posedge sys_clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t fa, f1, f2, f3, f4, f5, f6;
    fa = {BEATS{4'hA}};

    // Power-up reset
    repeat (3) @(posedge sys_clk);
    #1;
    model_reset();
    chk("por_ready",  frame_t'(o_ready),       frame_t'(0));
    chk("por_fvalid", frame_t'(o_frame_valid), frame_t'(0));
    chk("por_held",   frame_t'(o_held),        frame_t'(0));
    chk("por_err",    frame_t'(o_err),         frame_t'(0));
    rst = 1'b1;
    idle(1);
    chk("rel_ready", frame_t'(o_ready), frame_t'(1));

    // All-1010 frame
    send_frame(fa, 0, 1'b0, 1'b0);
    chk("a_fvalid", frame_t'(o_frame_valid), frame_t'(1));
    chk("a_held",   frame_t'(o_held),        frame_t'(1));
    chk("a_frame",  o_frame,                 fa);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("a_acked", frame_t'(o_held), frame_t'(0));

    // Beats without sof in IDLE are dropped silently
    for (int i = 0; i < 5; i++) step(1'b1, IN_W'($urandom), 1'b0, 1'b0, 1'b0);
    chk("nosof_held", frame_t'(o_held), frame_t'(0));
    chk("nosof_err",  frame_t'(o_err),  frame_t'(0));

    // Early sof at beat 30 restarts the frame
    partial(30);
    f2 = rand_frame();
    step(1'b1, f2[FRAME_W-1 -: IN_W], 1'b1, 1'b0, 1'b0);
    chk("trunc_err", frame_t'(o_err), frame_t'(1));
    send_frame(f2, 1, 1'b0, 1'b0);
    chk("trunc_frame", o_frame, f2);
    chk("trunc_held",  frame_t'(o_held), frame_t'(1));
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Three frames back-to-back: third stalls until an ack frees a bank
    f1 = rand_frame(); f2 = rand_frame(); f3 = rand_frame();
    send_frame(f1, 0, 1'b0, 1'b0);
    send_frame(f2, 0, 1'b0, 1'b0);
    chk("full_held",  frame_t'(o_held),  frame_t'(2));
    chk("full_ready", frame_t'(o_ready), frame_t'(0));
    chk("full_frame", o_frame, f1);
    send_frame(f3, 0, 1'b0, 1'b1);
    chk("order2", o_frame, f2);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("order3", o_frame, f3);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("drained", frame_t'(o_held), frame_t'(0));

    // Completion and ack in the same cycle
    f4 = rand_frame(); f5 = rand_frame();
    send_frame(f4, 0, 1'b0, 1'b0);
    send_frame(f5, 0, 1'b1, 1'b0);
    chk("same_held",  frame_t'(o_held), frame_t'(1));
    chk("same_frame", o_frame, f5);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Flush with two held frames, concurrent transfer and ack
    send_frame(rand_frame(), 0, 1'b0, 1'b0);
    send_frame(rand_frame(), 0, 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b1, 1'b1, 1'b1);
    chk("flush_held",   frame_t'(o_held),        frame_t'(0));
    chk("flush_fvalid", frame_t'(o_frame_valid), frame_t'(0));
    chk("flush_ready",  frame_t'(o_ready),       frame_t'(1));
    // Flush with a held frame and a partial one; the tail must be dropped
    f6 = rand_frame();
    send_frame(f6, 0, 1'b0, 1'b0);
    partial(10);
    step(1'b1, 4'h3, 1'b0, 1'b1, 1'b1);
    send_frame(rand_frame(), 10, 1'b0, 1'b0);
    chk("flush_idle_held", frame_t'(o_held), frame_t'(0));

    // Reset mid-frame with a buffered frame
    send_frame(rand_frame(), 0, 1'b0, 1'b0);
    partial(20);
    do_reset();
    idle(1);
    send_frame(rand_frame(), 20, 1'b0, 1'b0);
    chk("rstmid_held", frame_t'(o_held), frame_t'(0));
    chk("rstmid_err",  frame_t'(o_err),  frame_t'(0));

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      step(($urandom_range(3) != 0), IN_W'($urandom), ($urandom_range(99) == 0),
           ($urandom_range(699) == 0), ($urandom_range(39) == 0));
      if (m_in == 1'b0 && $urandom_range(3) == 0)
        step(1'b1, IN_W'($urandom), 1'b1, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
